// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: accepts one instruction at a time, drives the 8-bit ALU,
// then writes back the registered ALU result or resolves a branch into the PC.
// Holds the 8x8 register file and the carry flag of the last retired add.
module alu_issue_ctrl #(
    parameter int         NREGS    = 8,
    parameter logic [7:0] PC_RESET = 8'h00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_instr,
    output logic [7:0]  alu_reg1,
    output logic [7:0]  alu_reg2,
    output logic [3:0]  alu_func,
    output logic [2:0]  alu_spec_fun,
    input  logic [7:0]  alu_res,
    input  logic        alu_carry,
    input  logic        alu_br,
    output logic        done,
    output logic        illegal,
    output logic        carry_flag,
    output logic [7:0]  pc,
    input  logic [2:0]  dbg_addr,
    output logic [7:0]  dbg_data
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    localparam logic [3:0] FUNC_ADD  = 4'b0000;
    localparam logic [3:0] FUNC_SET  = 4'b0101;
    localparam logic [3:0] FUNC_SPEC = 4'b0111;
    localparam logic [3:0] FUNC_BE   = 4'b1100;
    localparam logic [3:0] FUNC_BLT  = 4'b1101;

    state_t      state_q, state_d;
    logic [14:0] instr_q, instr_d;   // in_instr[15:1]; bit 0 is reserved
    logic [7:0]  pc_q, pc_d;
    logic        carry_q, carry_d;
    logic        done_q, done_d;
    logic        illegal_q, illegal_d;
    logic        ready_q, ready_d;
    logic [7:0]  rf_q [NREGS];
    logic [7:0]  rf_d [NREGS];

    // Reserved instruction bit carries no meaning
    logic unused_reserved;
    assign unused_reserved = in_instr[0];

    // Fields of the latched instruction (indices shifted by one, bit 0 dropped)
    logic [3:0] func_w;
    logic [2:0] ra_w;
    logic [2:0] rb_w;
    logic       imm_sel_w;
    logic [3:0] imm4_w;
    logic       is_branch_w;
    logic [7:0] br_offset_w;

    assign func_w      = instr_q[14:11];
    assign ra_w        = instr_q[10:8];
    assign rb_w        = instr_q[7:5];
    assign imm_sel_w   = instr_q[4];
    assign imm4_w      = instr_q[3:0];
    assign is_branch_w = (func_w == FUNC_BE) || (func_w == FUNC_BLT);
    assign br_offset_w = {{4{imm4_w[3]}}, imm4_w};

    // Only these function codes are forwarded to the ALU
    function automatic logic func_legal(input logic [3:0] f);
        case (f)
            4'b0000, 4'b0011, 4'b0100, 4'b0101, 4'b0110,
            4'b0111, 4'b1010, 4'b1011, 4'b1100, 4'b1101: func_legal = 1'b1;
            default:                                      func_legal = 1'b0;
        endcase
    endfunction

    // Next-state, writeback and pc/flag update logic
    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        pc_d      = pc_q;
        carry_d   = carry_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        rf_d      = rf_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (func_legal(in_instr[15:12])) begin
                        instr_d = in_instr[15:1];
                        state_d = S_ISSUE;
                    end else begin
                        // Rejected words are skipped: pc advances, nothing else changes
                        illegal_d = 1'b1;
                        pc_d      = pc_q + 8'd1;
                    end
                end
            end
            S_ISSUE: begin
                // done is registered, so it rises together with CAPTURE
                state_d = S_CAPTURE;
                done_d  = 1'b1;
            end
            S_CAPTURE: begin
                state_d = S_IDLE;
                if (is_branch_w) begin
                    pc_d = alu_br ? (pc_q + br_offset_w) : (pc_q + 8'd1);
                end else begin
                    rf_d[ra_w] = alu_res;
                    pc_d       = pc_q + 8'd1;
                    if (func_w == FUNC_ADD) begin
                        carry_d = alu_carry;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        ready_d = (state_d == S_IDLE);
    end

    // State, register file and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            instr_q   <= '0;
            pc_q      <= PC_RESET;
            carry_q   <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            ready_q   <= 1'b1;
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            pc_q      <= pc_d;
            carry_q   <= carry_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
            ready_q   <= ready_d;
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= rf_d[i];
            end
        end
    end

    // ALU operand drive: real operands only in ISSUE, a harmless set-to-zero otherwise
    always_comb begin
        alu_func     = FUNC_SET;
        alu_reg1     = 8'h00;
        alu_reg2     = 8'h00;
        alu_spec_fun = 3'b000;
        if (state_q == S_ISSUE) begin
            alu_func = func_w;
            alu_reg1 = rf_q[ra_w];
            // Branches always compare two registers; imm4 is their offset
            alu_reg2 = (imm_sel_w && !is_branch_w) ? {4'b0000, imm4_w} : rf_q[rb_w];
            if (func_w == FUNC_SPEC) begin
                alu_spec_fun = rb_w;
            end
        end
    end

    assign in_ready   = ready_q;
    assign done       = done_q;
    assign illegal    = illegal_q;
    assign carry_flag = carry_q;
    assign pc         = pc_q;
    assign dbg_data   = rf_q[dbg_addr];

endmodule
